reg_universal: RTL and testbench



---
 rtl/sap_pkg.sv | 16 +
 rtl/reg_universal_next.sv | 72 +++++++
 rtl/reg_universal.sv | 64 ++++++
 tb/tb_reg_universal.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP datapath definitions.
// Holds the universal register operation codes.
package sap_pkg;

  localparam int REGU_MODE_W = 3;

  localparam logic [REGU_MODE_W-1:0] REGU_MODE_HOLD = 3'b000;
  localparam logic [REGU_MODE_W-1:0] REGU_MODE_INC  = 3'b001;
  localparam logic [REGU_MODE_W-1:0] REGU_MODE_DEC  = 3'b010;
  localparam logic [REGU_MODE_W-1:0] REGU_MODE_SHL  = 3'b011;
  localparam logic [REGU_MODE_W-1:0] REGU_MODE_SHR  = 3'b100;
  localparam logic [REGU_MODE_W-1:0] REGU_MODE_ROL  = 3'b101;
  localparam logic [REGU_MODE_W-1:0] REGU_MODE_ROR  = 3'b110;
  localparam logic [REGU_MODE_W-1:0] REGU_MODE_CLR  = 3'b111;

endpackage

// File: rtl/reg_universal_next.sv
// Next-state logic for the universal register (value and carry).
// REG_UNIVERSAL_SAT_EN makes INC/DEC saturate instead of wrap.
module reg_universal_next
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]       value_i,
  input  logic                   carry_i,
  input  logic [REGU_MODE_W-1:0] mode_i,
  input  logic                   ser_in_i,
  output logic [WIDTH-1:0]       next_value_o,
  output logic                   next_carry_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic all_ones;
  logic all_zero;

  assign all_ones = &value_i;
  assign all_zero = ~|value_i;

  // Decode the operation; unknown codes fall back to hold.
  always_comb begin
    next_value_o = value_i;
    next_carry_o = carry_i;
    case (mode_i)
      REGU_MODE_INC: begin
`ifdef REG_UNIVERSAL_SAT_EN
        next_value_o = all_ones ? value_i : value_i + ONE;
`else
        next_value_o = value_i + ONE;
`endif
        next_carry_o = all_ones;
      end
      REGU_MODE_DEC: begin
`ifdef REG_UNIVERSAL_SAT_EN
        next_value_o = all_zero ? value_i : value_i - ONE;
`else
        next_value_o = value_i - ONE;
`endif
        next_carry_o = all_zero;
      end
      REGU_MODE_SHL: begin
        next_value_o = {value_i[WIDTH-2:0], ser_in_i};
        next_carry_o = value_i[WIDTH-1];
      end
      REGU_MODE_SHR: begin
        next_value_o = {ser_in_i, value_i[WIDTH-1:1]};
        next_carry_o = value_i[0];
      end
      REGU_MODE_ROL: begin
        next_value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
        next_carry_o = value_i[WIDTH-1];
      end
      REGU_MODE_ROR: begin
        next_value_o = {value_i[0], value_i[WIDTH-1:1]};
        next_carry_o = value_i[0];
      end
      REGU_MODE_CLR: begin
        next_value_o = '0;
        next_carry_o = 1'b0;
      end
      default: begin
        next_value_o = value_i;
        next_carry_o = carry_i;
      end
    endcase
  end

endmodule

// File: rtl/reg_universal.sv
// Universal SAP register: load/count/shift/rotate with tri-state bus.
// Optional saturating INC/DEC via REG_UNIVERSAL_SAT_EN.
module reg_universal
  import sap_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   low_i_en,
  input  logic [REGU_MODE_W-1:0] mode,
  input  logic                   ser_in,
  input  logic                   low_o_en,
  output logic [WIDTH-1:0]       out,
  output wire  [WIDTH-1:0]       bus_out,
  output logic                   carry,
  output logic                   zero
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             carry_q;
  logic             carry_d;
  logic [WIDTH-1:0] op_value;
  logic             op_carry;

  reg_universal_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .value_i      (value_q),
    .carry_i      (carry_q),
    .mode_i       (mode),
    .ser_in_i     (ser_in),
    .next_value_o (op_value),
    .next_carry_o (op_carry)
  );

  // Priority: reset, then parallel load, then mode operation.
  always_comb begin
    value_d = op_value;
    carry_d = op_carry;
    if (sync_reset) begin
      value_d = RESET_VAL;
      carry_d = 1'b0;
    end else if (!low_i_en) begin
      value_d = in;
      carry_d = 1'b0;
    end
  end

  // State register; reset is folded into value_d/carry_d.
  always_ff @(posedge clk) begin
    value_q <= value_d;
    carry_q <= carry_d;
  end

  assign out     = value_q;
  assign carry   = carry_q;
  assign zero    = ~|value_q;
  assign bus_out = low_o_en ? {WIDTH{1'bz}} : value_q;

endmodule

// File: tb/tb_reg_universal.sv
// Self-checking bench for reg_universal (WIDTH=4, RESET_VAL=0101).
// Vector table plus scoreboard queue, and bus driver sequences.
module tb_reg_universal;
  import sap_pkg::*;

  localparam int W = 4;
  localparam logic [W-1:0] RV = 4'b0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         sync_reset;
  logic [W-1:0] in_d;
  logic         low_i_en;
  logic [2:0]   mode;
  logic         ser_in;
  logic         low_o_en;
  logic [W-1:0] out_w;
  wire  [W-1:0] bus_w;
  logic         carry_w;
  logic         zero_w;

  for (genvar g = 0; g < W; g++) begin : g_pu
    pullup (bus_w[g]);
  end

  reg_universal #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .in         (in_d),
    .low_i_en   (low_i_en),
    .mode       (mode),
    .ser_in     (ser_in),
    .low_o_en   (low_o_en),
    .out        (out_w),
    .bus_out    (bus_w),
    .carry      (carry_w),
    .zero       (zero_w)
  );

  typedef struct {
    logic         rst;
    logic         lie;
    logic [2:0]   md;
    logic         ser;
    logic [W-1:0] din;
    logic [W-1:0] eo;
    logic         ec;
  } vec_t;

  typedef struct {
    logic [W-1:0] o;
    logic         c;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", nm, idx, act, req);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    sync_reset = v.rst;
    low_i_en   = v.lie;
    mode       = v.md;
    ser_in     = v.ser;
    in_d       = v.din;
    sb.push_back('{v.eo, v.ec});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty[%0d]", idx);
    end else begin
      e = sb.pop_front();
      chk("out", idx, out_w, e.o);
      chk("carry", idx, {3'b000, carry_w}, {3'b000, e.c});
      chk("zero", idx, {3'b000, zero_w}, {3'b000, (e.o == '0)});
    end
  endtask

  localparam logic [2:0] H = REGU_MODE_HOLD;

  initial begin
    sync_reset = 1'b0;
    low_i_en   = 1'b1;
    mode       = H;
    ser_in     = 1'b0;
    in_d       = '0;
    low_o_en   = 1'b1;

    //          rst  lie  mode           ser  in       out      c
    tv.push_back('{1'b1, 1'b0, H,             1'b0, 4'b1111, 4'b0101, 1'b0});
    tv.push_back('{1'b0, 1'b0, H,             1'b0, 4'b1010, 4'b1010, 1'b0});
    tv.push_back('{1'b0, 1'b1, H,             1'b0, 4'b1111, 4'b1010, 1'b0});
    tv.push_back('{1'b0, 1'b1, H,             1'b0, 4'b1111, 4'b1010, 1'b0});
    tv.push_back('{1'b0, 1'b1, H,             1'b0, 4'b1111, 4'b1010, 1'b0});
    tv.push_back('{1'b0, 1'b0, REGU_MODE_DEC, 1'b0, 4'b1110, 4'b1110, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_INC, 1'b0, 4'b0000, 4'b1111, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_INC, 1'b0, 4'b0000, 4'b0000, 1'b1});
    tv.push_back('{1'b0, 1'b1, H,             1'b0, 4'b0000, 4'b0000, 1'b1});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_DEC, 1'b0, 4'b0000, 4'b1111, 1'b1});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_DEC, 1'b0, 4'b0000, 4'b1110, 1'b0});
    tv.push_back('{1'b0, 1'b0, REGU_MODE_SHL, 1'b0, 4'b1001, 4'b1001, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_SHL, 1'b0, 4'b0000, 4'b0010, 1'b1});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_SHR, 1'b1, 4'b0000, 4'b1001, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_ROL, 1'b0, 4'b0000, 4'b0011, 1'b1});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_ROR, 1'b1, 4'b0000, 4'b1001, 1'b1});
    tv.push_back('{1'b0, 1'b0, REGU_MODE_INC, 1'b0, 4'b0000, 4'b0000, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_INC, 1'b0, 4'b0000, 4'b0001, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_INC, 1'b0, 4'b0000, 4'b0010, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_INC, 1'b0, 4'b0000, 4'b0011, 1'b0});
    tv.push_back('{1'b1, 1'b1, REGU_MODE_INC, 1'b0, 4'b0000, 4'b0101, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_INC, 1'b0, 4'b0000, 4'b0110, 1'b0});
    tv.push_back('{1'b0, 1'b0, H,             1'b0, 4'b0111, 4'b0111, 1'b0});
    tv.push_back('{1'b0, 1'b0, REGU_MODE_CLR, 1'b0, 4'b1100, 4'b1100, 1'b0});
    tv.push_back('{1'b0, 1'b1, REGU_MODE_CLR, 1'b0, 4'b1100, 4'b0000, 1'b0});

    foreach (tv[i]) step(tv[i], i);

    // Bus driver: released bus reads the pull-ups, enabled bus shows out.
    low_o_en = 1'b1;
    #1;
    chk("bus_off", 0, bus_w, 4'b1111);
    low_o_en = 1'b0;
    #1;
    chk("bus_on", 0, bus_w, 4'b0000);

    // Drive and load in the same cycle: old value until the edge.
    low_i_en = 1'b0;
    in_d     = 4'b1010;
    #1;
    chk("bus_pre", 0, bus_w, 4'b0000);
    step('{1'b0, 1'b0, H, 1'b0, 4'b1010, 4'b1010, 1'b0}, 100);
    chk("bus_post", 0, bus_w, 4'b1010);
    low_o_en = 1'b1;
    #1;
    chk("bus_off2", 0, bus_w, 4'b1111);
    low_o_en = 1'b0;
    #1;
    chk("bus_on2", 0, bus_w, 4'b1010);

    // Hold with low_i_en=1 must ignore in even while bus is driven.
    step('{1'b0, 1'b1, H, 1'b0, 4'b0001, 4'b1010, 1'b0}, 101);
    chk("bus_hold", 0, bus_w, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
